// File: rtl/alarm_timer_scheduler.sv
// Interval timer and delay-parameter store for the anti-theft controller.
// Holds the four reprogrammable delays, derives the one-second tick from the
// system clock and runs one interval at a time, answering with a one-cycle
// expiry pulse.
module alarm_timer_scheduler #(
  parameter int PRESCALE      = 8,
  parameter int DEF_ARM       = 6,
  parameter int DEF_DRIVER    = 8,
  parameter int DEF_PASSENGER = 15,
  parameter int DEF_ALARM_ON  = 10
) (
  input  logic       clock,
  input  logic       systemReset,
  input  logic       reprogram,
  input  logic [1:0] paramSelect,
  input  logic [3:0] timeValue,
  input  logic       startTimer,
  input  logic [1:0] intervalSelect,
  input  logic       intervalDouble,
  output logic       expired,
  output logic       running,
  output logic [4:0] remaining,
  output logic       oneHzEnable
);

  localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    arm_q, driver_q, passenger_q, alarm_on_q;
  logic [PW-1:0] pre_q;
  logic [4:0]    remaining_q, remaining_d;
  logic [3:0]    sel_val;
  logic [4:0]    load_n;
  logic          start_ok;
  logic          tick;

  // A write always wins over a simultaneous start request.
  assign start_ok    = startTimer & ~reprogram;
  assign tick        = (pre_q == PRE_LAST);
  assign oneHzEnable = tick;
  assign remaining   = remaining_q;

  // Pick the stored delay addressed by the start request.
  always_comb begin
    sel_val = arm_q;
    case (intervalSelect)
      2'd0:    sel_val = arm_q;
      2'd1:    sel_val = driver_q;
      2'd2:    sel_val = passenger_q;
      default: sel_val = alarm_on_q;
    endcase
  end

  // Doubling is a plain shift; 15 s doubled still fits in five bits.
  assign load_n = intervalDouble ? {sel_val, 1'b0} : {1'b0, sel_val};

  // Parameter store: defaults on reset, single-register write on reprogram.
  always_ff @(posedge clock or posedge systemReset) begin
    if (systemReset) begin
      arm_q       <= 4'(DEF_ARM);
      driver_q    <= 4'(DEF_DRIVER);
      passenger_q <= 4'(DEF_PASSENGER);
      alarm_on_q  <= 4'(DEF_ALARM_ON);
    end else if (reprogram) begin
      case (paramSelect)
        2'd0:    arm_q       <= timeValue;
        2'd1:    driver_q    <= timeValue;
        2'd2:    passenger_q <= timeValue;
        default: alarm_on_q  <= timeValue;
      endcase
    end
  end

  // Free-running prescaler, re-phased on every accepted start so the first
  // tick lands exactly PRESCALE cycles after the start edge.
  always_ff @(posedge clock or posedge systemReset) begin
    if (systemReset) begin
      pre_q <= '0;
    end else if (start_ok || tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  // FSM state and seconds-remaining registers.
  always_ff @(posedge clock or posedge systemReset) begin
    if (systemReset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  // Next-state and output decode; abort and restart override the current phase.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    running     = (state_q == COUNT);
    expired     = (state_q == DONE);
    if (reprogram) begin
      state_d     = IDLE;
      remaining_d = '0;
    end else if (startTimer) begin
      remaining_d = load_n;
      state_d     = (load_n != 5'd0) ? COUNT : DONE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        COUNT: begin
          if (tick) begin
            if (remaining_q <= 5'd1) begin
              remaining_d = '0;
              state_d     = DONE;
            end else begin
              remaining_d = remaining_q - 5'd1;
            end
          end
        end
        DONE: begin
          state_d     = IDLE;
          remaining_d = '0;
        end
        default: begin
          state_d     = IDLE;
          remaining_d = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_timer_scheduler.sv
// Directed bench for alarm_timer_scheduler with a 4-cycle prescaler.
module tb_alarm_timer_scheduler;

  logic       clock = 1'b0;
  logic       systemReset = 1'b0;
  logic       reprogram = 1'b0;
  logic [1:0] paramSelect = 2'd0;
  logic [3:0] timeValue = 4'd0;
  logic       startTimer = 1'b0;
  logic [1:0] intervalSelect = 2'd0;
  logic       intervalDouble = 1'b0;
  logic       expired;
  logic       running;
  logic [4:0] remaining;
  logic       oneHzEnable;

  int n_cmp = 0;
  int n_bad = 0;

  alarm_timer_scheduler #(
    .PRESCALE(4)
  ) dut (
    .clock         (clock),
    .systemReset   (systemReset),
    .reprogram     (reprogram),
    .paramSelect   (paramSelect),
    .timeValue     (timeValue),
    .startTimer    (startTimer),
    .intervalSelect(intervalSelect),
    .intervalDouble(intervalDouble),
    .expired       (expired),
    .running       (running),
    .remaining     (remaining),
    .oneHzEnable   (oneHzEnable)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int want);
    n_cmp++;
    if (obs != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, want);
    end
  endtask

  // Advance one clock; outputs are read 1 ns after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic write_reg(input logic [1:0] sel, input logic [3:0] val);
    reprogram   = 1'b1;
    paramSelect = sel;
    timeValue   = val;
    step();
    reprogram   = 1'b0;
  endtask

  task automatic start(input logic [1:0] sel, input logic dbl);
    startTimer     = 1'b1;
    intervalSelect = sel;
    intervalDouble = dbl;
    step();
    startTimer     = 1'b0;
    intervalDouble = 1'b0;
  endtask

  // Cycles from the start edge until expired is seen, plus ticks while running.
  task automatic wait_expired(output int cyc, output int ticks);
    cyc   = 0;
    ticks = 0;
    while (!expired && cyc < 200) begin
      if (oneHzEnable && running) ticks++;
      step();
      cyc++;
    end
  endtask

  int cyc, ticks, exp_seen;

  initial begin
    // Reset state
    systemReset = 1'b1;
    step();
    step();
    check("rst_expired", int'(expired), 0);
    check("rst_running", int'(running), 0);
    check("rst_remaining", int'(remaining), 0);
    check("rst_onehz", int'(oneHzEnable), 0);
    systemReset = 1'b0;
    step();

    // Default arm delay: 6 s -> 24 cycles
    start(2'd0, 1'b0);
    check("arm_remaining", int'(remaining), 6);
    check("arm_running", int'(running), 1);
    wait_expired(cyc, ticks);
    check("arm_latency", cyc, 24);
    check("arm_ticks", ticks, 6);
    step();
    check("arm_pulse_width", int'(expired), 0);
    check("arm_idle_running", int'(running), 0);

    // Reset mid-count restores defaults and clears outputs at once
    write_reg(2'd0, 4'd2);
    start(2'd0, 1'b0);
    check("arm2_remaining", int'(remaining), 2);
    step();
    step();
    systemReset = 1'b1;
    #1;
    check("amid_running", int'(running), 0);
    check("amid_remaining", int'(remaining), 0);
    check("amid_expired", int'(expired), 0);
    check("amid_onehz", int'(oneHzEnable), 0);
    step();
    systemReset = 1'b0;
    step();
    start(2'd0, 1'b0);
    check("def_restored", int'(remaining), 6);
    wait_expired(cyc, ticks);
    check("def_latency", cyc, 24);
    step();

    // Doubled passenger delay: 30 s -> 120 cycles, 30 ticks
    start(2'd2, 1'b1);
    check("dbl_remaining", int'(remaining), 30);
    wait_expired(cyc, ticks);
    check("dbl_latency", cyc, 120);
    check("dbl_ticks", ticks, 30);
    step();

    // Reprogrammed driver delay
    write_reg(2'd1, 4'd3);
    start(2'd1, 1'b0);
    check("drv3_remaining", int'(remaining), 3);
    wait_expired(cyc, ticks);
    check("drv3_latency", cyc, 12);
    step();
    write_reg(2'd1, 4'd0);
    start(2'd1, 1'b0);
    check("drv0_expired", int'(expired), 1);
    check("drv0_running", int'(running), 0);
    check("drv0_remaining", int'(remaining), 0);
    step();
    check("drv0_pulse_width", int'(expired), 0);

    // Abort alarm-on interval by reprogram at remaining = 5
    start(2'd3, 1'b0);
    check("abort_load", int'(remaining), 10);
    for (int i = 0; i < 20; i++) step();
    check("abort_at5", int'(remaining), 5);
    write_reg(2'd0, 4'd6);
    check("abort_running", int'(running), 0);
    check("abort_remaining", int'(remaining), 0);
    exp_seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (expired) exp_seen++;
      step();
    end
    check("abort_no_expired", exp_seen, 0);

    // Retrigger arm interval at remaining = 2
    start(2'd0, 1'b0);
    for (int i = 0; i < 16; i++) step();
    check("retrig_at2", int'(remaining), 2);
    start(2'd0, 1'b0);
    check("retrig_reload", int'(remaining), 6);
    wait_expired(cyc, ticks);
    check("retrig_latency", cyc, 24);
    step();

    // Simultaneous write and start: write wins, stays idle
    reprogram      = 1'b1;
    paramSelect    = 2'd0;
    timeValue      = 4'd5;
    startTimer     = 1'b1;
    intervalSelect = 2'd0;
    step();
    reprogram  = 1'b0;
    startTimer = 1'b0;
    check("coll_running", int'(running), 0);
    check("coll_remaining", int'(remaining), 0);
    exp_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (expired) exp_seen++;
      step();
    end
    check("coll_no_expired", exp_seen, 0);
    start(2'd0, 1'b0);
    check("coll_reg_updated", int'(remaining), 5);
    wait_expired(cyc, ticks);
    check("coll_latency", cyc, 20);
    step();

    // Select lines toggling during count have no effect
    start(2'd3, 1'b0);
    check("stab_load", int'(remaining), 10);
    for (int i = 1; i <= 40; i++) begin
      intervalSelect = intervalSelect + 2'd1;
      intervalDouble = ~intervalDouble;
      step();
      if (i == 8)  check("stab_rem8", int'(remaining), 8);
      if (i == 36) check("stab_rem1", int'(remaining), 1);
      if (i == 39) check("stab_not_yet", int'(expired), 0);
      if (i == 40) check("stab_expired", int'(expired), 1);
    end
    intervalDouble = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alarm_timer_scheduler.md
Name: alarm_timer_scheduler

Overview:
- Programmable interval timer and parameter store that sequences every timed phase of the anti-theft controller: arm delay, driver-door delay, passenger-door delay and siren-on duration.
- The alarm FSM requests an interval by select code and gets a single-cycle expiry pulse back.
- Holds the four field-reprogrammable delay values and generates the one-second tick from the system clock.

Parameters:
- PRESCALE, 8, clock cycles per one-second tick (simulation value; set to clock frequency in hardware)
- DEF_ARM, 6, reset value of arm-delay register (seconds)
- DEF_DRIVER, 8, reset value of driver-delay register
- DEF_PASSENGER, 15, reset value of passenger-delay register
- DEF_ALARM_ON, 10, reset value of siren-on register

Ports:
- clock  input  1  system clock, rising-edge
- systemReset  input  1  asynchronous, active-high reset
- reprogram  input  1  one-cycle write strobe for parameter store
- paramSelect  input  2  register written on reprogram: 0 arm, 1 driver, 2 passenger, 3 alarm-on
- timeValue  input  4  value written on reprogram (0..15 s)
- startTimer  input  1  one-cycle request to start an interval
- intervalSelect  input  2  interval to run on startTimer, same encoding as paramSelect
- intervalDouble  input  1  sampled with startTimer; doubles the interval
- expired  output  1  one-cycle pulse at end of interval
- running  output  1  high while an interval is counting
- remaining  output  5  seconds left in current interval
- oneHzEnable  output  1  one-cycle tick every PRESCALE clocks

Behaviour:
- Reset (async, any time, including mid-interval): parameter registers = DEF_* values; state IDLE; prescaler = 0; remaining = 0; expired = 0; running = 0.
- Parameter store: on reprogram, timeValue is written into the register chosen by paramSelect at that edge. A value of 0 is stored as-is.
- Prescaler: free-running 0..PRESCALE-1, wraps to 0. oneHzEnable = (prescaler == PRESCALE-1), decoded from the register. Forced to 0 on any accepted startTimer, so the first tick occurs exactly PRESCALE cycles after the start edge.
- Effective length: N = selected register, zero-extended to 5 bits, shifted left 1 if intervalDouble = 1 at the start edge. Maximum is 30. No saturation is needed.
- FSM states: IDLE, COUNT, DONE.
  - IDLE: on startTimer, load remaining = N. Go to COUNT if N > 0, else go to DONE.
  - COUNT: running = 1. On each oneHzEnable, remaining decrements. On the tick where remaining == 1, remaining becomes 0 and the state goes to DONE.
  - DONE: expired = 1 for exactly this one cycle, then go to IDLE. remaining stays 0.
- Latency: with start sampled at edge E0, expired is high in the cycle following edge E0 + N*PRESCALE. For N = 0, expired is high in the cycle following E0.
- startTimer in COUNT or DONE: restart with the new N and reset the prescaler. No expired is issued for the aborted interval.
- reprogram in any state: abort the current interval. State goes to IDLE, remaining = 0, no expired. Defaults are not re-applied.
- reprogram and startTimer in the same cycle: the write takes effect and startTimer is ignored. The state ends in IDLE.
- Changes to intervalSelect or intervalDouble while in COUNT have no effect; both are sampled only on an accepted start.
- Writing a register while its interval is idle affects the next start only.

Test Plan (PRESCALE = 4 unless noted):
- Reset defaults: assert systemReset, release, start intervalSelect = 0 -> remaining = 6, running = 1; expired high in the cycle after edge E0+24. Release-reset mid-count -> all outputs 0 immediately.
- Doubling: start intervalSelect = 2, intervalDouble = 1 -> remaining = 30; expired after 120 cycles; exactly 30 oneHzEnable pulses observed while running.
- Reprogram: write paramSelect = 1, timeValue = 3, then start intervalSelect = 1 -> expired after 12 cycles. Write timeValue = 0 and start -> expired in the cycle after the start edge, running never high.
- Abort: start alarm-on (10 s), pulse reprogram at remaining = 5 -> running drops next cycle, remaining = 0, no expired for 60 following cycles.
- Retrigger and collision: start arm (6 s), re-pulse startTimer at remaining = 2 -> remaining reloads to 6, expired at 24 cycles after the second start. Simultaneous reprogram + startTimer -> register updated, state IDLE, no expired.
- Select stability: toggle intervalSelect and intervalDouble every cycle during COUNT -> remaining sequence and expiry timing unchanged from the latched values.
